// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Shares the tile's component register bus between N_REQ masters. Each
//   master issues single 32-bit reads/writes; addr[15:8] selects the
//   component, addr[7:0] the register. Transactions are serialised with
//   round-robin fairness, and only one is outstanding at a time. A read is
//   turned into an error response if the component stays silent for
//   TIMEOUT cycles, or if the component ID is out of range.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   req_valid/write/addr/wdata per-master request (held until req_ready)
//   req_ready                 one-hot 1-cycle accept pulse
//   resp_valid/ready          per-master response handshake
//   resp_data, resp_err       response payload for the granted master
//   reg_bus_w*/ar*            one-hot strobes, {8'h0,reg} addresses, wdata
//   reg_bus_rvalid/rdata      per-component read return
module reg_bus_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned N_COMP   = 16,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [N_REQ*16-1:0]    req_addr,
  input  logic [N_REQ*32-1:0]    req_wdata,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic [15:0]            reg_bus_waddr,
  output logic [31:0]            reg_bus_wdata,
  output logic [N_COMP-1:0]      reg_bus_wvalid,
  output logic [N_COMP-1:0]      reg_bus_arvalid,
  output logic [15:0]            reg_bus_araddr,
  input  logic [N_COMP-1:0]      reg_bus_rvalid,
  input  logic [N_COMP*32-1:0]   reg_bus_rdata
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = (N_COMP > 1) ? $clog2(N_COMP) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic [TW-1:0]   timer;
  logic            lat_write;
  logic [CW-1:0]   comp_idx;

  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  int unsigned     cand;
  logic [15:0]     pick_addr;
  logic [CW-1:0]   pick_cidx;
  logic            pick_bad;
  logic            cur_rvalid;
  logic [31:0]     cur_rdata;

  // Cyclic search starting at rr_ptr; the first pending master wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_found && req_valid[IDW'(cand)]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(cand);
      end
    end
  end

  assign pick_addr  = req_addr[32'(pick_id)*16 +: 16];
  assign pick_cidx  = pick_addr[8 +: CW];
  assign pick_bad   = ({24'd0, pick_addr[15:8]} >= N_COMP);
  assign cur_rvalid = reg_bus_rvalid[comp_idx];
  assign cur_rdata  = reg_bus_rdata[32'(comp_idx)*32 +: 32];

  // The accept pulse is decoded in the same cycle the request is seen so
  // that the strobe lands exactly one cycle after acceptance; it is gated
  // by rstn so nothing is accepted while reset is held.
  assign req_ready = (rstn && state == IDLE && pick_found)
                     ? (N_REQ'(1) << pick_id) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      timer           <= '0;
      lat_write       <= 1'b0;
      comp_idx        <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      resp_err        <= 1'b0;
      reg_bus_waddr   <= '0;
      reg_bus_araddr  <= '0;
      reg_bus_wdata   <= '0;
      reg_bus_wvalid  <= '0;
      reg_bus_arvalid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id       <= pick_id;
            lat_write      <= req_write[pick_id];
            comp_idx       <= pick_cidx;
            reg_bus_waddr  <= {8'h00, pick_addr[7:0]};
            reg_bus_araddr <= {8'h00, pick_addr[7:0]};
            reg_bus_wdata  <= req_wdata[32'(pick_id)*32 +: 32];
            if (pick_bad) begin
              resp_valid <= N_REQ'(1) << pick_id;
              resp_err   <= 1'b1;
              resp_data  <= req_write[pick_id] ? 32'h0 : ERR_DATA;
              state      <= RESP;
            end else begin
              // Strobes are registered on entry so they are high only in ISSUE.
              if (req_write[pick_id]) reg_bus_wvalid  <= N_COMP'(1) << pick_cidx;
              else                    reg_bus_arvalid <= N_COMP'(1) << pick_cidx;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          reg_bus_wvalid  <= '0;
          reg_bus_arvalid <= '0;
          timer           <= '0;
          if (lat_write) begin
            resp_valid <= N_REQ'(1) << grant_id;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            state      <= RESP;
          end else begin
            state <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (cur_rvalid) begin
            resp_valid <= N_REQ'(1) << grant_id;
            resp_err   <= 1'b0;
            resp_data  <= cur_rdata;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_valid <= N_REQ'(1) << grant_id;
            resp_err   <= 1'b1;
            resp_data  <= ERR_DATA;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[grant_id]) begin
            resp_valid     <= '0;
            resp_err       <= 1'b0;
            resp_data      <= '0;
            reg_bus_waddr  <= '0;
            reg_bus_araddr <= '0;
            reg_bus_wdata  <= '0;
            rr_ptr         <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter
//   Directed bench for reg_bus_arbiter (N_REQ=2, N_COMP=16, TIMEOUT=8).
//   Single-master transactions come from a vector table; round-robin
//   alternation, late read data after a timeout and reset during a read
//   are exercised by hand-written sequences.
module tb_reg_bus_arbiter;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    req_valid, req_write, req_ready, resp_valid, resp_ready;
  logic [31:0]   req_addr;
  logic [63:0]   req_wdata;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [15:0]   reg_bus_waddr, reg_bus_araddr;
  logic [31:0]   reg_bus_wdata;
  logic [15:0]   reg_bus_wvalid, reg_bus_arvalid, reg_bus_rvalid;
  logic [511:0]  reg_bus_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.N_REQ(2), .N_COMP(16), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .reg_bus_waddr(reg_bus_waddr), .reg_bus_wdata(reg_bus_wdata),
    .reg_bus_wvalid(reg_bus_wvalid), .reg_bus_arvalid(reg_bus_arvalid),
    .reg_bus_araddr(reg_bus_araddr), .reg_bus_rvalid(reg_bus_rvalid),
    .reg_bus_rdata(reg_bus_rdata)
  );

  typedef struct {
    int          m;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          k;        // rvalid k cycles after arvalid; 0 = never
    logic [31:0] rdata;
    logic [15:0] exp_wv;
    logic [15:0] exp_av;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;  // cycles from accept to resp_valid
    int          hold;     // cycles resp_ready is withheld
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    resp_ready = '0; reg_bus_rvalid = '0; reg_bus_rdata = '0;
  endtask

  task automatic outs_zero(input string name);
    chk(name, {30'd0, |{req_ready, resp_valid, resp_data, resp_err, reg_bus_waddr,
               reg_bus_araddr, reg_bus_wdata, reg_bus_wvalid, reg_bus_arvalid}, 1'b0}, 32'd0);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic run_txn(input vec_t v);
    int t_acc, t_str, t_rsp, n_str;
    bit ok_hold, released;
    logic [3:0] comp, oth;
    logic [1:0] oh;
    t_acc = -1; t_str = -1; t_rsp = -1; n_str = 0; ok_hold = 1; released = 0;
    comp = v.addr[11:8]; oth = comp + 4'd1; oh = 2'b01 << v.m;
    req_write[v.m] = v.wr;
    req_addr[v.m*16 +: 16] = v.addr;
    req_wdata[v.m*32 +: 32] = v.wdata;
    req_valid[v.m] = 1'b1;
    for (int c = 0; c < 40 && !released; c++) begin
      if (t_acc >= 0 && c == t_acc + 1) req_valid[v.m] = 1'b0;
      reg_bus_rvalid = '0;
      reg_bus_rdata  = {16{32'h5555_AAAA}};
      if (t_str >= 0 && !v.wr && c == t_str + 1) begin
        reg_bus_rvalid[oth] = 1'b1;  // stray answer from a neighbour
        reg_bus_rdata[oth*32 +: 32] = 32'hBAD0_0000;
      end
      if (t_str >= 0 && !v.wr && v.k > 0 && c == t_str + v.k) begin
        reg_bus_rvalid[comp] = 1'b1;
        reg_bus_rdata[comp*32 +: 32] = v.rdata;
      end
      #1;
      if (req_ready != 0) begin
        chk("req_ready", {30'd0, req_ready}, {30'd0, oh});
        if (t_acc < 0) t_acc = c;
      end
      if ((reg_bus_wvalid | reg_bus_arvalid) != 0) begin
        n_str++;
        t_str = c;
        chk("wvalid", {16'd0, reg_bus_wvalid}, {16'd0, v.exp_wv});
        chk("arvalid", {16'd0, reg_bus_arvalid}, {16'd0, v.exp_av});
        chk("strobe_lat", c - t_acc, 1);
        if (v.wr) begin
          chk("waddr", {16'd0, reg_bus_waddr}, {24'd0, v.addr[7:0]});
          chk("wdata", reg_bus_wdata, v.wdata);
        end else begin
          chk("araddr", {16'd0, reg_bus_araddr}, {24'd0, v.addr[7:0]});
        end
      end
      if (resp_valid != 0) begin
        if (t_rsp < 0) begin
          t_rsp = c;
          chk("resp_valid", {30'd0, resp_valid}, {30'd0, oh});
          chk("resp_data", resp_data, v.exp_data);
          chk("resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
          chk("resp_lat", c - t_acc, v.exp_lat);
        end else if (resp_valid !== oh || resp_data !== v.exp_data || resp_err !== v.exp_err) begin
          ok_hold = 0;
        end
        if (c == t_rsp + v.hold) resp_ready[v.m] = 1'b1;
      end else if (t_rsp >= 0) begin
        released = 1;
      end
      if (!released) @(negedge clk);
    end
    chk("txn_done", {31'd0, released}, 32'd1);
    chk("resp_hold", {31'd0, ok_hold}, 32'd1);
    chk("n_strobe", n_str, ((v.exp_wv | v.exp_av) != 0) ? 1 : 0);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, got;
    bit ok;
    vecs[0] = '{0, 1'b1, 16'h0310, 32'h0000_1234, 0, 32'h0,         16'h0008, 16'h0000, 32'h0,         1'b0, 2,  0};
    vecs[1] = '{1, 1'b0, 16'h0504, 32'h0,         3, 32'hCAFE_0001, 16'h0000, 16'h0020, 32'hCAFE_0001, 1'b0, 5,  2};
    vecs[2] = '{0, 1'b0, 16'h0F3C, 32'h0,         1, 32'h0000_00F1, 16'h0000, 16'h8000, 32'h0000_00F1, 1'b0, 3,  0};
    vecs[3] = '{1, 1'b0, 16'h0600, 32'h0,         0, 32'h0,         16'h0000, 16'h0040, 32'hDEAD_BEEF, 1'b1, 10, 0};
    vecs[4] = '{0, 1'b0, 16'h2004, 32'h0,         0, 32'h0,         16'h0000, 16'h0000, 32'hDEAD_BEEF, 1'b1, 1,  1};
    vecs[5] = '{1, 1'b1, 16'h1055, 32'h0000_0077, 0, 32'h0,         16'h0000, 16'h0000, 32'h0,         1'b1, 1,  0};
    vecs[6] = '{0, 1'b0, 16'h0108, 32'h0,         8, 32'h1111_2222, 16'h0000, 16'h0002, 32'h1111_2222, 1'b0, 10, 0};
    vecs[7] = '{1, 1'b1, 16'h0A7F, 32'hFFFF_FFFF, 0, 32'h0,         16'h0400, 16'h0000, 32'h0,         1'b0, 2,  1};

    // Reset with requests pending: nothing may be accepted or driven.
    idle_inputs();
    rstn = 1'b0;
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    outs_zero("reset_outs");
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;

    // Both masters requesting continuously from reset: 0,1,0,1.
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {16'h0204, 16'h0104}; req_wdata = {32'hB, 32'hA};
    resp_ready = 2'b11;
    n_acc = 0;
    for (int c = 0; c < 60 && n_acc < 4; c++) begin
      #1;
      if (req_ready != 0) begin
        got = (req_ready == 2'b10) ? 1 : 0;
        chk("rr_onehot", {31'd0, ^req_ready}, 32'd1);
        chk("rr_order", got, n_acc % 2);
        n_acc++;
      end
      @(negedge clk);
    end
    chk("rr_count", n_acc, 4);
    req_valid = '0;
    repeat (6) @(negedge clk);
    idle_inputs();
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Timeout on component 2, then a late answer must not produce a response.
    run_txn('{0, 1'b0, 16'h0210, 32'h0, 0, 32'h0, 16'h0000, 16'h0004, 32'hDEAD_BEEF, 1'b1, 10, 0});
    ok = 1;
    reg_bus_rvalid[2] = 1'b1;
    reg_bus_rdata[2*32 +: 32] = 32'hCAFE_CAFE;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (resp_valid != 0 || reg_bus_arvalid != 0) ok = 0;
      @(negedge clk);
      if (c == 1) reg_bus_rvalid = '0;
    end
    chk("late_rvalid_ignored", {31'd0, ok}, 32'd1);
    idle_inputs();

    // Reset while master1 waits on component 3; rr_ptr would otherwise favour master1.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[31:16] = 16'h0300;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      #1;
      if (req_ready[1]) ok = 1;
      @(negedge clk);
    end
    chk("abort_accept", {31'd0, ok}, 32'd1);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    outs_zero("abort_reset_outs");
    rstn = 1'b1;
    reg_bus_rvalid[3] = 1'b1;
    reg_bus_rdata[3*32 +: 32] = 32'h0BAD_F00D;
    ok = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) reg_bus_rvalid = '0;
      #1;
      if (resp_valid != 0 || resp_err != 0 || resp_data != 0) ok = 0;
    end
    chk("abort_no_resp", {31'd0, ok}, 32'd1);
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {16'h0104, 16'h0104};
    #1;
    chk("post_reset_first", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = '0;
    resp_ready = 2'b11;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (resp_valid == 2'b01 && !resp_err) ok = 1;
      @(negedge clk);
    end
    chk("post_reset_resp", {31'd0, ok}, 32'd1);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
